ddr_fifo_responder: RTL

Responder end of the cache command interface: accepts line-sized (128-bit) write and read commands from the AXI4 line cache and drives the Gowin DDR3 memory-interface user port. Write commands carry one line plus a byte mask. Read commands return `burst_cnt+1` consecutive lines on the response channel. Sits between the line cache and the DDR3 IP in the same 27 MHz domain.

---
 rtl/ddr_fifo_responder_pkg.sv | 23 ++
 rtl/ddr_fifo_responder_rsp_fifo.sv | 71 +++++++
 rtl/ddr_fifo_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_fifo_responder_pkg.sv
// Shared types and constants for ddr_fifo_responder.
// CREDIT follows DDR_FIFO_RESPONDER_RSP_FIFO_EN (response FIFO present or not).
package ddr_fifo_responder_pkg;

    localparam int   LINE_W = 128;
    localparam int   MASK_W = 16;
    localparam logic CMD_WR = 1'b0;
    localparam logic CMD_RD = 1'b1;

`ifdef DDR_FIFO_RESPONDER_RSP_FIFO_EN
    localparam int   CREDIT = 4;
`else
    localparam int   CREDIT = 2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR       = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/ddr_fifo_responder_rsp_fifo.sv
// Depth-4 response FIFO with occupancy count, plus its overflow checker.
// Only instantiated when DDR_FIFO_RESPONDER_RSP_FIFO_EN is defined.
module rsp_fifo_chk (
    input logic clk,
    input logic rstn,
    input logic push_i,
    input logic pop_i,
    input logic full_i
);
    // A push into a full FIFO is only legal when a pop frees the slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push_i && full_i && !pop_i))
        else $error("rsp_fifo: push while full");
endmodule

module rsp_fifo #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic [2:0]   count_o
);
    logic [W-1:0] mem_q [4];
    logic [1:0]   wr_ptr_q;
    logic [1:0]   rd_ptr_q;
    logic [2:0]   count_q;
    logic         full_s;
    logic         do_push_s;
    logic         do_pop_s;

    assign full_s    = (count_q == 3'd4);
    assign do_pop_s  = pop_i && (count_q != 3'd0);
    assign do_push_s = push_i && (!full_s || do_pop_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {2'd0, do_push_s} - {2'd0, do_pop_s};
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == 3'd0);
    assign count_o = count_q;

    rsp_fifo_chk u_chk (
        .clk    (clk),
        .rstn   (rstn),
        .push_i (push_i),
        .pop_i  (pop_i),
        .full_i (full_s)
    );
endmodule

// File: rtl/ddr_fifo_responder.sv
// Cache-command responder driving the Gowin DDR3 user port.
// Optional 4-entry response FIFO: define DDR_FIFO_RESPONDER_RSP_FIFO_EN.
module ddr_fifo_responder
    import ddr_fifo_responder_pkg::*;
#(
    parameter int ADDR_W    = 27,
    parameter int ADDR_STEP = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              io_fifo_cmd_valid,
    output logic              io_fifo_cmd_ready,
    input  logic              io_fifo_cmd_type,
    input  logic [ADDR_W-1:0] io_fifo_cmd_addr,
    input  logic [5:0]        io_fifo_cmd_burst_cnt,
    input  logic [LINE_W-1:0] io_fifo_cmd_wt_data,
    input  logic [MASK_W-1:0] io_fifo_cmd_wt_mask,
    output logic              io_fifo_rsp_valid,
    input  logic              io_fifo_rsp_ready,
    output logic [LINE_W-1:0] io_fifo_rsp_data,
    input  logic              ddr_init_done,
    output logic [2:0]        ddr_cmd,
    output logic              ddr_cmd_en,
    input  logic              ddr_cmd_ready,
    output logic [ADDR_W-1:0] ddr_addr,
    output logic [LINE_W-1:0] ddr_wr_data,
    output logic              ddr_wr_data_en,
    output logic              ddr_wr_data_end,
    output logic [MASK_W-1:0] ddr_wr_data_mask,
    input  logic              ddr_wr_data_rdy,
    input  logic [LINE_W-1:0] ddr_rd_data,
    input  logic              ddr_rd_data_valid,
    output logic              err_burst_wr
);
    state_e            state_q, state_d;
    logic              run_q;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [5:0]        burst_q, burst_d;
    logic [6:0]        issued_q, issued_d;
    logic [6:0]        received_q, received_d;
    logic [2:0]        cmd_q, cmd_d;
    logic              cmd_en_q, cmd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [LINE_W-1:0] wr_data_q, wr_data_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              err_q, err_d;

    logic              cmd_fire_s;
    logic              cmd_hs_s;
    logic              rd_accept_s;
    logic              rsp_empty_s;
    logic [6:0]        beats_s;
    logic [6:0]        pend_s;
    logic [ADDR_W-1:0] line_addr_s;
    logic              unused_s;

    // run_q keeps the command port closed while reset is asserted.
    assign io_fifo_cmd_ready = run_q && ddr_init_done && (state_q == ST_IDLE);
    assign cmd_fire_s        = io_fifo_cmd_valid && io_fifo_cmd_ready;
    assign cmd_hs_s          = cmd_en_q && ddr_cmd_ready;
    assign beats_s           = {1'b0, burst_q} + 7'd1;
    assign line_addr_s       = {io_fifo_cmd_addr[ADDR_W-1:4], 4'h0};
    // Read data is only taken while a read is actually outstanding.
    assign rd_accept_s       = ddr_rd_data_valid && (issued_q != received_q) &&
                               ((state_q == ST_RD_ISSUE) || (state_q == ST_RD_DRAIN));

`ifdef DDR_FIFO_RESPONDER_RSP_FIFO_EN
    logic [2:0] fifo_count_s;

    rsp_fifo #(.W(LINE_W)) u_rsp_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (rd_accept_s),
        .din_i   (ddr_rd_data),
        .pop_i   (io_fifo_rsp_valid && io_fifo_rsp_ready),
        .dout_o  (io_fifo_rsp_data),
        .empty_o (rsp_empty_s),
        .count_o (fifo_count_s)
    );
    assign io_fifo_rsp_valid = ~rsp_empty_s;
    assign unused_s          = ^io_fifo_cmd_addr[3:0];
`else
    logic              rsp_valid_q;
    logic [LINE_W-1:0] rsp_data_q;

    // Single response register: one-cycle pulse per returned beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rd_accept_s;
            if (rd_accept_s) begin
                rsp_data_q <= ddr_rd_data;
            end
        end
    end
    assign io_fifo_rsp_valid = rsp_valid_q;
    assign io_fifo_rsp_data  = rsp_data_q;
    assign rsp_empty_s       = ~rsp_valid_q;
    assign unused_s          = ^{io_fifo_cmd_addr[3:0], io_fifo_rsp_ready};
`endif

    // Next-state and next-output logic for the command FSM.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        addr_d     = addr_q;
        burst_d    = burst_q;
        issued_d   = issued_q;
        received_d = received_q + {6'd0, rd_accept_s};
        cmd_d      = cmd_q;
        cmd_en_d   = cmd_en_q;
        wr_en_d    = wr_en_q;
        wr_data_d  = wr_data_q;
        mask_d     = mask_q;
        err_d      = err_q;
        pend_s     = 7'd0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    base_d     = line_addr_s;
                    addr_d     = line_addr_s;
                    burst_d    = io_fifo_cmd_burst_cnt;
                    issued_d   = 7'd0;
                    received_d = 7'd0;
                    cmd_en_d   = 1'b1;
                    if (io_fifo_cmd_type == CMD_WR) begin
                        state_d   = ST_WR;
                        cmd_d     = {2'b00, CMD_WR};
                        wr_en_d   = 1'b1;
                        wr_data_d = io_fifo_cmd_wt_data;
                        mask_d    = io_fifo_cmd_wt_mask;
                        err_d     = err_q | (io_fifo_cmd_burst_cnt != 6'd0);
                    end else begin
                        state_d = ST_RD_ISSUE;
                        cmd_d   = {2'b00, CMD_RD};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                cmd_en_d = cmd_en_q & ~ddr_cmd_ready;
                wr_en_d  = wr_en_q & ~ddr_wr_data_rdy;
                if (!cmd_en_d && !wr_en_d) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_RD_ISSUE: begin
                if (cmd_hs_s) begin
                    issued_d = issued_q + 7'd1;
                end else begin
                    issued_d = issued_q;
                end
`ifdef DDR_FIFO_RESPONDER_RSP_FIFO_EN
                // Beats parked in the FIFO still hold credit until popped.
                pend_s = issued_d - received_q + {4'd0, fifo_count_s};
`else
                pend_s = issued_d - received_d;
`endif
                if (issued_d == beats_s) begin
                    cmd_en_d = 1'b0;
                    state_d  = ST_RD_DRAIN;
                end else begin
                    addr_d = base_q + ADDR_W'(issued_d) * ADDR_W'(ADDR_STEP);
                    if (cmd_en_q && !ddr_cmd_ready) begin
                        cmd_en_d = 1'b1;
                    end else begin
                        cmd_en_d = (pend_s < 7'(CREDIT));
                    end
                end
            end
            ST_RD_DRAIN: begin
                if ((received_q == beats_s) && rsp_empty_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered DDR-side outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            base_q     <= '0;
            addr_q     <= '0;
            burst_q    <= 6'd0;
            issued_q   <= 7'd0;
            received_q <= 7'd0;
            cmd_q      <= 3'd0;
            cmd_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            mask_q     <= 16'hFFFF;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            base_q     <= base_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            cmd_q      <= cmd_d;
            cmd_en_q   <= cmd_en_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            mask_q     <= mask_d;
            err_q      <= err_d;
        end
    end

    assign ddr_cmd          = cmd_q;
    assign ddr_cmd_en       = cmd_en_q;
    assign ddr_addr         = addr_q;
    assign ddr_wr_data      = wr_data_q;
    assign ddr_wr_data_en   = wr_en_q;
    assign ddr_wr_data_end  = wr_en_q;
    assign ddr_wr_data_mask = mask_q;
    assign err_burst_wr     = err_q;

endmodule
